hazard_ctrl: RTL and testbench



---
 rtl/hazard_ctrl.sv | 147 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use stalls, branch flushes, bus-busy
// freezes with a watchdog, and saturating stall/flush performance counters.
module hazard_ctrl #(
  parameter int REG_BITS = 5,
  parameter int MAX_WAIT = 255,
  parameter int CNT_BITS = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [REG_BITS-1:0] id_rs,
  input  logic [REG_BITS-1:0] id_rt,
  input  logic                id_uses_rt,
  input  logic                ex_mem_read,
  input  logic [REG_BITS-1:0] ex_rt,
  input  logic                branch_taken,
  input  logic                mem_busy,
  output logic                pc_write,
  output logic                ifid_write,
  output logic                ifid_flush,
  output logic                idex_bubble,
  output logic                pipe_hold,
  output logic                mem_timeout,
  output logic [CNT_BITS-1:0] stall_cnt,
  output logic [CNT_BITS-1:0] flush_cnt,
  output logic [1:0]          state
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_t;

  localparam int WAIT_BITS = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_BITS-1:0]  CNT_MAX = {CNT_BITS{1'b1}};
  localparam logic [WAIT_BITS-1:0] WAIT_LIMIT = WAIT_BITS'(MAX_WAIT);

  state_t               state_q, state_d;
  logic [WAIT_BITS-1:0] wait_q, wait_d;
  logic [CNT_BITS-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_BITS-1:0]  flush_cnt_q, flush_cnt_d;
  logic                 mem_timeout_q, mem_timeout_d;
  logic                 load_use_s;
  logic                 frozen_s;
  logic [WAIT_BITS-1:0] wait_inc_s;

  // Load-use hazard detection; r0 is hardwired zero so never creates a dependency.
  always_comb begin
    load_use_s = ex_mem_read && (ex_rt != {REG_BITS{1'b0}}) &&
                 ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  end

  // Next-state, counter and pipeline-control logic in priority order.
  always_comb begin
    pc_write      = 1'b1;
    ifid_write    = 1'b1;
    ifid_flush    = 1'b0;
    idex_bubble   = 1'b0;
    pipe_hold     = 1'b0;
    state_d       = state_q;
    wait_d        = wait_q;
    stall_cnt_d   = stall_cnt_q;
    flush_cnt_d   = flush_cnt_q;
    mem_timeout_d = mem_timeout_q;
    wait_inc_s    = wait_q + WAIT_BITS'(1);

    // Any encoding other than RUN/MEM_WAIT is treated as the locked error state.
    case (state_q)
      ST_RUN:      frozen_s = 1'b0;
      ST_MEM_WAIT: frozen_s = 1'b0;
      default:     frozen_s = 1'b1;
    endcase

    if (reset) begin
      pc_write      = 1'b0;
      ifid_write    = 1'b0;
      ifid_flush    = 1'b1;
      idex_bubble   = 1'b1;
      pipe_hold     = 1'b0;
      state_d       = ST_RUN;
      wait_d        = {WAIT_BITS{1'b0}};
      stall_cnt_d   = {CNT_BITS{1'b0}};
      flush_cnt_d   = {CNT_BITS{1'b0}};
      mem_timeout_d = 1'b0;
    end else if (frozen_s) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      pipe_hold  = 1'b1;
      state_d    = ST_ERROR;
    end else if (mem_busy) begin
      // Branch/load-use are ignored: the frozen EX stage re-presents them later.
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      pipe_hold  = 1'b1;
      wait_d     = wait_inc_s;
      if (stall_cnt_q != CNT_MAX) begin
        stall_cnt_d = stall_cnt_q + CNT_BITS'(1);
      end else begin
        stall_cnt_d = stall_cnt_q;
      end
      if (wait_inc_s >= WAIT_LIMIT) begin
        state_d       = ST_ERROR;
        mem_timeout_d = 1'b1;
      end else begin
        state_d = ST_MEM_WAIT;
      end
    end else begin
      state_d = ST_RUN;
      wait_d  = {WAIT_BITS{1'b0}};
      if (branch_taken) begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        if (flush_cnt_q != CNT_MAX) begin
          flush_cnt_d = flush_cnt_q + CNT_BITS'(1);
        end else begin
          flush_cnt_d = flush_cnt_q;
        end
      end else if (load_use_s) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
        if (stall_cnt_q != CNT_MAX) begin
          stall_cnt_d = stall_cnt_q + CNT_BITS'(1);
        end else begin
          stall_cnt_d = stall_cnt_q;
        end
      end else begin
        pc_write = 1'b1;
      end
    end
  end

  // State, watchdog and counter registers (reset is folded into the _d logic).
  always_ff @(posedge clock) begin
    state_q       <= state_d;
    wait_q        <= wait_d;
    stall_cnt_q   <= stall_cnt_d;
    flush_cnt_q   <= flush_cnt_d;
    mem_timeout_q <= mem_timeout_d;
  end

  assign state       = state_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;
  assign mem_timeout = mem_timeout_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed, table-driven bench for hazard_ctrl (MAX_WAIT=8, CNT_BITS=4).
module tb_hazard_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, ex_mem_read, branch_taken, mem_busy;
  logic       pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, mem_timeout;
  logic [3:0] stall_cnt, flush_cnt;
  logic [1:0] state;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  hazard_ctrl #(.REG_BITS(5), .MAX_WAIT(8), .CNT_BITS(4)) dut (
    .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .branch_taken(branch_taken), .mem_busy(mem_busy), .pc_write(pc_write),
    .ifid_write(ifid_write), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .pipe_hold(pipe_hold), .mem_timeout(mem_timeout), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt), .state(state)
  );

  typedef struct {
    logic       rst;
    logic [4:0] rs, rt;
    logic       uses_rt, mrd;
    logic [4:0] ert;
    logic       br, busy;
    logic       chk_q;
    logic       e_pc, e_ifw, e_fl, e_bub, e_hold;
    logic [1:0] e_st;
    logic [3:0] e_stall, e_flush;
    logic       e_to;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                     input logic uses_rt, input logic mrd, input logic [4:0] ert,
                     input logic br, input logic busy, input logic chk_q,
                     input logic e_pc, input logic e_ifw, input logic e_fl,
                     input logic e_bub, input logic e_hold, input logic [1:0] e_st,
                     input logic [3:0] e_stall, input logic [3:0] e_flush,
                     input logic e_to);
    vec_t v;
    v = '{rst, rs, rt, uses_rt, mrd, ert, br, busy, chk_q,
          e_pc, e_ifw, e_fl, e_bub, e_hold, e_st, e_stall, e_flush, e_to};
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive inputs just after the falling edge so outputs settle before the next rise.
  task automatic drive(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                       input logic uses_rt, input logic mrd, input logic [4:0] ert,
                       input logic br, input logic busy);
    @(negedge clock);
    reset = rst; id_rs = rs; id_rt = rt; id_uses_rt = uses_rt;
    ex_mem_read = mrd; ex_rt = ert; branch_taken = br; mem_busy = busy;
    #1;
  endtask

  initial begin
    reset = 1'b1; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
    ex_mem_read = 1'b0; ex_rt = 5'd0; branch_taken = 1'b0; mem_busy = 1'b0;

    //   rst   rs     rt     urt   mrd   ert    br    busy  chkq  pc    ifw   fl    bub   hold  st     stall  flush  to
    add(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 4'd0, 4'd0, 1'b0);
    add(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 4'd0, 4'd0, 1'b0);
    add(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 4'd0, 1'b0);
    add(1'b0, 5'd5, 5'd2, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 4'd0, 4'd0, 1'b0);
    add(1'b0, 5'd5, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd1, 4'd0, 1'b0);
    add(1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd1, 4'd0, 1'b0);
    add(1'b0, 5'd1, 5'd3, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 4'd1, 4'd0, 1'b0);
    add(1'b0, 5'd1, 5'd3, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd2, 4'd0, 1'b0);
    add(1'b0, 5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 4'd2, 4'd0, 1'b0);
    add(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd2, 4'd1, 1'b0);
    // Bus freeze with a taken branch held: branch waits, then fires on release.
    add(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 4'd2, 4'd1, 1'b0);
    add(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 4'd3, 4'd1, 1'b0);
    add(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 4'd4, 4'd1, 1'b0);
    add(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 4'd5, 4'd1, 1'b0);
    add(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 4'd6, 4'd1, 1'b0);
    add(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd6, 4'd2, 1'b0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].rs, vecs[i].rt, vecs[i].uses_rt,
            vecs[i].mrd, vecs[i].ert, vecs[i].br, vecs[i].busy);
      chk($sformatf("v%0d pc_write", i),    int'(pc_write),    int'(vecs[i].e_pc));
      chk($sformatf("v%0d ifid_write", i),  int'(ifid_write),  int'(vecs[i].e_ifw));
      chk($sformatf("v%0d ifid_flush", i),  int'(ifid_flush),  int'(vecs[i].e_fl));
      chk($sformatf("v%0d idex_bubble", i), int'(idex_bubble), int'(vecs[i].e_bub));
      chk($sformatf("v%0d pipe_hold", i),   int'(pipe_hold),   int'(vecs[i].e_hold));
      if (vecs[i].chk_q) begin
        chk($sformatf("v%0d state", i),       int'(state),       int'(vecs[i].e_st));
        chk($sformatf("v%0d stall_cnt", i),   int'(stall_cnt),   int'(vecs[i].e_stall));
        chk($sformatf("v%0d flush_cnt", i),   int'(flush_cnt),   int'(vecs[i].e_flush));
        chk($sformatf("v%0d mem_timeout", i), int'(mem_timeout), int'(vecs[i].e_to));
      end else begin
        checks = checks;
      end
    end

    // Continuous load-use from stall_cnt=6: must stop at 15 and never wrap.
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 5'd9, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0);
      chk("sat_bubble", int'(idex_bubble), 1);
      chk("sat_stall_cnt", int'(stall_cnt), (6 + i > 15) ? 15 : 6 + i);
    end
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    chk("sat_final", int'(stall_cnt), 15);

    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    chk("rst_stall_cnt", int'(stall_cnt), 0);
    chk("rst_flush_cnt", int'(flush_cnt), 0);

    // Watchdog: 8 busy cycles tolerated, then locked in ERROR until reset.
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
      chk("wd_pipe_hold", int'(pipe_hold), 1);
      chk("wd_pc_write", int'(pc_write), 0);
      chk("wd_state", int'(state), (i == 0) ? 0 : ((i < 8) ? 1 : 2));
      chk("wd_timeout", int'(mem_timeout), (i < 8) ? 0 : 1);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
      chk("err_state", int'(state), 2);
      chk("err_timeout", int'(mem_timeout), 1);
      chk("err_pc_write", int'(pc_write), 0);
      chk("err_flush", int'(ifid_flush), 0);
      chk("err_pipe_hold", int'(pipe_hold), 1);
    end
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    chk("err_rst_flush", int'(ifid_flush), 1);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    chk("post_err_state", int'(state), 0);
    chk("post_err_timeout", int'(mem_timeout), 0);
    chk("post_err_pc_write", int'(pc_write), 1);
    chk("post_err_flush_cnt", int'(flush_cnt), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
